// File: rtl/ocs_slot_sched.sv
// rtl/ocs_slot_sched.sv - OCS slot/guard scheduler with link-readiness qualification
// Arms after a stable all-ready window, then alternates SLOT/GUARD until any channel drops.
module ocs_slot_sched #(
   parameter logic [31:0] P_SLOT_LEN  = 32'd1000,
   parameter logic [31:0] P_GUARD_LEN = 32'd64,
   parameter logic [15:0] P_READY_CNT = 16'd256,
   parameter logic [15:0] P_ARM_LEN   = 16'd32
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [7:0]  i_chnl_ready,
   output logic        o_new_slot_start,
   output logic        o_slot_id,
   output logic [63:0] o_time_stamp,
   output logic        o_guard,
   output logic        o_ocs_switch,
   output logic        o_ocs_next_id,
   output logic        o_running,
   output logic        o_link_lost,
   output logic [31:0] o_slot_cnt
);

   typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_SLOT, ST_GUARD} state_t;

   state_t      state_q, state_d;
   logic        all_ready_q;
   logic [15:0] stable_q, stable_d;
   logic [15:0] arm_q, arm_d;
   logic [31:0] slot_q, slot_d;
   logic [31:0] guard_q, guard_d;
   logic        slot_id_q, slot_id_d;
   logic [31:0] slot_cnt_q, slot_cnt_d;
   logic        new_slot_q, new_slot_d;
   logic        ocs_sw_q, ocs_sw_d;
   logic        ocs_next_q, ocs_next_d;
   logic        link_lost_q, link_lost_d;
   logic [63:0] ts_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         all_ready_q <= 1'b0;
         stable_q    <= '0;
         arm_q       <= '0;
         slot_q      <= '0;
         guard_q     <= '0;
         slot_id_q   <= 1'b0;
         slot_cnt_q  <= '0;
         new_slot_q  <= 1'b0;
         ocs_sw_q    <= 1'b0;
         ocs_next_q  <= 1'b0;
         link_lost_q <= 1'b0;
         ts_q        <= '0;
      end else begin
         state_q     <= state_d;
         all_ready_q <= &i_chnl_ready;
         stable_q    <= stable_d;
         arm_q       <= arm_d;
         slot_q      <= slot_d;
         guard_q     <= guard_d;
         slot_id_q   <= slot_id_d;
         slot_cnt_q  <= slot_cnt_d;
         new_slot_q  <= new_slot_d;
         ocs_sw_q    <= ocs_sw_d;
         ocs_next_q  <= ocs_next_d;
         link_lost_q <= link_lost_d;
         ts_q        <= ts_q + 64'd1;
      end
   end

   always_comb begin
      state_d     = state_q;
      stable_d    = stable_q;
      arm_d       = arm_q;
      slot_d      = slot_q;
      guard_d     = guard_q;
      slot_id_d   = slot_id_q;
      slot_cnt_d  = slot_cnt_q;
      new_slot_d  = 1'b0;
      ocs_sw_d    = 1'b0;
      ocs_next_d  = ocs_next_q;
      link_lost_d = 1'b0;

      if (state_q != ST_IDLE && !all_ready_q) begin
         // Loss outranks any boundary event falling in the same cycle.
         state_d     = ST_IDLE;
         link_lost_d = 1'b1;
         stable_d    = '0;
         arm_d       = '0;
         slot_d      = '0;
         guard_d     = '0;
         slot_id_d   = 1'b0;
         slot_cnt_d  = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (!all_ready_q) begin
                  stable_d = '0;
               end else if (stable_q == P_READY_CNT - 16'd1) begin
                  state_d  = ST_ARM;
                  stable_d = '0;
                  arm_d    = '0;
               end else begin
                  stable_d = stable_q + 16'd1;
               end
            end
            ST_ARM: begin
               if (arm_q == P_ARM_LEN - 16'd1) begin
                  state_d    = ST_SLOT;
                  arm_d      = '0;
                  slot_d     = '0;
                  slot_id_d  = 1'b0;
                  slot_cnt_d = 32'd1;
                  new_slot_d = 1'b1;
               end else begin
                  arm_d = arm_q + 16'd1;
               end
            end
            ST_SLOT: begin
               if (slot_q == P_SLOT_LEN - 32'd1) begin
                  state_d    = ST_GUARD;
                  guard_d    = '0;
                  ocs_sw_d   = 1'b1;
                  ocs_next_d = ~slot_id_q;
               end else begin
                  slot_d = slot_q + 32'd1;
               end
            end
            ST_GUARD: begin
               if (guard_q == P_GUARD_LEN - 32'd1) begin
                  state_d    = ST_SLOT;
                  slot_d     = '0;
                  slot_id_d  = ~slot_id_q;
                  slot_cnt_d = slot_cnt_q + 32'd1;
                  new_slot_d = 1'b1;
               end else begin
                  guard_d = guard_q + 32'd1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign o_new_slot_start = new_slot_q;
   assign o_slot_id        = slot_id_q;
   assign o_time_stamp     = ts_q;
   assign o_guard          = (state_q == ST_GUARD);
   assign o_ocs_switch     = ocs_sw_q;
   assign o_ocs_next_id    = ocs_next_q;
   assign o_running        = (state_q == ST_SLOT) || (state_q == ST_GUARD);
   assign o_link_lost      = link_lost_q;
   assign o_slot_cnt       = slot_cnt_q;

endmodule

// File: tb/tb_ocs_slot_sched.sv
// tb/tb_ocs_slot_sched.sv - bench for ocs_slot_sched
// Cycle n is the state after the n-th clock edge following reset release.
module tb_ocs_slot_sched;

   localparam int SL = 10;
   localparam int GL = 3;
   localparam int RC = 4;
   localparam int AL = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  chnl;
   logic        new_slot, slot_id, guard, ocs_sw, ocs_nid, running, link_lost;
   logic [63:0] ts;
   logic [31:0] slot_cnt;

   ocs_slot_sched #(
      .P_SLOT_LEN(32'd10), .P_GUARD_LEN(32'd3), .P_READY_CNT(16'd4), .P_ARM_LEN(16'd5)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_chnl_ready(chnl),
      .o_new_slot_start(new_slot), .o_slot_id(slot_id), .o_time_stamp(ts),
      .o_guard(guard), .o_ocs_switch(ocs_sw), .o_ocs_next_id(ocs_nid),
      .o_running(running), .o_link_lost(link_lost), .o_slot_cnt(slot_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: schedule derived from arm time with div/mod arithmetic.
   int  n, run, start;
   bit  active, r_m, m_nid;
   bit  e_ns, e_sid, e_guard, e_sw, e_run, e_ll;
   logic [31:0] e_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, n, act, exp);
      end
   endtask

   task automatic model_reset();
      n = 0; run = 0; start = 0; active = 0; r_m = 0; m_nid = 0;
   endtask

   task automatic model_edge();
      int e, k, p;
      n++;
      e_ns = 0; e_sid = 0; e_guard = 0; e_sw = 0; e_run = 0; e_ll = 0; e_cnt = '0;
      if (!active) begin
         if (r_m) begin
            run++;
            if (run == RC) begin
               active = 1; start = n; run = 0;
            end
         end else begin
            run = 0;
         end
      end else if (!r_m) begin
         active = 0; e_ll = 1; run = 0;
      end else begin
         e = n - start - AL;
         if (e >= 0) begin
            k = e / (SL + GL);
            p = e % (SL + GL);
            e_run   = 1;
            e_sid   = k[0];
            e_cnt   = 32'(k + 1);
            e_ns    = (p == 0);
            e_guard = (p >= SL);
            if (p == SL) begin
               e_sw  = 1;
               m_nid = ~k[0];
            end
         end
      end
   endtask

   task automatic check_model();
      chk("m_new_slot", 64'(new_slot), 64'(e_ns));
      chk("m_slot_id", 64'(slot_id), 64'(e_sid));
      chk("m_guard", 64'(guard), 64'(e_guard));
      chk("m_ocs_switch", 64'(ocs_sw), 64'(e_sw));
      chk("m_ocs_next_id", 64'(ocs_nid), 64'(m_nid));
      chk("m_running", 64'(running), 64'(e_run));
      chk("m_link_lost", 64'(link_lost), 64'(e_ll));
      chk("m_slot_cnt", 64'(slot_cnt), 64'(e_cnt));
      chk("m_time_stamp", ts, 64'(n));
   endtask

   task automatic tick(input logic [7:0] ch);
      chnl = ch;
      @(posedge clk);
      model_edge();
      r_m = &ch;
      #1;
      check_model();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      chnl = 8'h00;
      @(negedge clk);
      @(negedge clk);
      model_reset();
      rst = 1'b0;
   endtask

   typedef struct {
      int          cyc;
      logic        ns, sid, grd, sw, nid, run;
      logic [31:0] cnt;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int first_pulse, ll_seen;
      logic [7:0] ch;
      rst = 1'b1;
      chnl = 8'h00;
      model_reset();
      #1;
      chk("reset_new_slot", 64'(new_slot), 64'd0);
      chk("reset_running", 64'(running), 64'd0);
      chk("reset_slot_cnt", 64'(slot_cnt), 64'd0);
      chk("reset_time_stamp", ts, 64'd0);

      // Steady run: expected snapshot at selected cycles.
      vecs.push_back('{9,  0, 0, 0, 0, 0, 0, 32'd0});
      vecs.push_back('{10, 1, 0, 0, 0, 0, 1, 32'd1});
      vecs.push_back('{11, 0, 0, 0, 0, 0, 1, 32'd1});
      vecs.push_back('{19, 0, 0, 0, 0, 0, 1, 32'd1});
      vecs.push_back('{20, 0, 0, 1, 1, 1, 1, 32'd1});
      vecs.push_back('{21, 0, 0, 1, 0, 1, 1, 32'd1});
      vecs.push_back('{22, 0, 0, 1, 0, 1, 1, 32'd1});
      vecs.push_back('{23, 1, 1, 0, 0, 1, 1, 32'd2});
      vecs.push_back('{33, 0, 1, 1, 1, 0, 1, 32'd2});
      vecs.push_back('{35, 0, 1, 1, 0, 0, 1, 32'd2});
      vecs.push_back('{36, 1, 0, 0, 0, 0, 1, 32'd3});
      do_reset();
      for (int i = 0; i < vecs.size(); i++) begin
         while (n < vecs[i].cyc) tick(8'hFF);
         chk("vec_new_slot", 64'(new_slot), 64'(vecs[i].ns));
         chk("vec_slot_id", 64'(slot_id), 64'(vecs[i].sid));
         chk("vec_guard", 64'(guard), 64'(vecs[i].grd));
         chk("vec_ocs_switch", 64'(ocs_sw), 64'(vecs[i].sw));
         chk("vec_ocs_next_id", 64'(ocs_nid), 64'(vecs[i].nid));
         chk("vec_running", 64'(running), 64'(vecs[i].run));
         chk("vec_slot_cnt", 64'(slot_cnt), 64'(vecs[i].cnt));
      end

      // Ready glitch in IDLE at stable count 2 delays the first slot by 3 cycles.
      do_reset();
      first_pulse = -1;
      ll_seen = 0;
      for (int i = 1; i <= 20; i++) begin
         tick((i == 3) ? 8'hFE : 8'hFF);
         if (new_slot && first_pulse < 0) first_pulse = n;
         if (link_lost) ll_seen++;
      end
      chk("glitch_first_pulse", 64'(first_pulse), 64'd13);
      chk("glitch_no_link_lost", 64'(ll_seen), 64'd0);

      // Drop mid-SLOT, then re-arm from scratch.
      do_reset();
      while (n < 13) tick(8'hFF);
      tick(8'h7F);
      tick(8'hFF);
      chk("drop_link_lost", 64'(link_lost), 64'd1);
      chk("drop_running", 64'(running), 64'd0);
      chk("drop_slot_cnt", 64'(slot_cnt), 64'd0);
      ll_seen = 0;
      first_pulse = -1;
      while (n < 24) begin
         tick(8'hFF);
         if (link_lost) ll_seen++;
         if (new_slot && first_pulse < 0) first_pulse = n;
      end
      chk("drop_single_pulse", 64'(ll_seen), 64'd0);
      chk("rearm_pulse_cycle", 64'(first_pulse), 64'd24);
      chk("rearm_slot_id", 64'(slot_id), 64'd0);
      chk("rearm_slot_cnt", 64'(slot_cnt), 64'd1);

      // Loss seen in the last GUARD cycle suppresses the slot boundary.
      do_reset();
      while (n < 21) tick(8'hFF);
      tick(8'hEF);
      chk("lastguard_guard", 64'(guard), 64'd1);
      tick(8'hFF);
      chk("lastguard_no_pulse", 64'(new_slot), 64'd0);
      chk("lastguard_link_lost", 64'(link_lost), 64'd1);
      chk("lastguard_guard_off", 64'(guard), 64'd0);

      // Asynchronous reset during GUARD.
      do_reset();
      while (n < 21) tick(8'hFF);
      #2;
      rst = 1'b1;
      #1;
      chk("areset_guard", 64'(guard), 64'd0);
      chk("areset_running", 64'(running), 64'd0);
      chk("areset_time_stamp", ts, 64'd0);
      chk("areset_slot_cnt", 64'(slot_cnt), 64'd0);
      chk("areset_ocs_next_id", 64'(ocs_nid), 64'd0);
      @(negedge clk);
      model_reset();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) tick(8'hFF);
      chk("areset_ts_restart", ts, 64'd5);

      // Randomised channel drops against the model.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         ch = 8'hFF;
         if ($urandom_range(0, 59) == 0) ch = 8'($urandom_range(0, 255));
         tick(ch);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
